// File: rtl/key_pkg.sv
// Shared types and defaults for the key debounce block.
package key_pkg;

  localparam int unsigned N_DEF          = 11;
  localparam int unsigned TICK_DIV_DEF   = 1000;
  localparam int unsigned DB_TICKS_DEF   = 20;
  localparam int unsigned HOLD_TICKS_DEF = 500;
  localparam int unsigned REP_TICKS_DEF  = 100;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } db_state_e;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: LOW/WAIT_HI/HIGH/WAIT_LO FSM with tick counter and
// registered press/release/auto-repeat pulses.
module debounce_chan
  import key_pkg::*;
#(
  parameter int unsigned DB_TICKS   = DB_TICKS_DEF,
  parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF,
  parameter int unsigned REP_TICKS  = REP_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic s,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned HR_MAX = (HOLD_TICKS > REP_TICKS) ? HOLD_TICKS : REP_TICKS;
  localparam int unsigned CMAX   = (DB_TICKS > HR_MAX) ? DB_TICKS : HR_MAX;
  localparam int unsigned CW     = cnt_width(CMAX);

  localparam logic [CW-1:0] DB_LAST   = CW'(DB_TICKS - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REP_TICKS - 1);

  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rep_phase_q, rep_phase_d;
  logic          press_d, release_d, repeat_d;
  logic [CW-1:0] hold_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOW;
      cnt_q         <= '0;
      rep_phase_q   <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rep_phase_q   <= rep_phase_d;
      press         <= press_d;
      release_pulse <= release_d;
      repeat_pulse  <= repeat_d;
    end
  end

  // First repeat waits HOLD_TICKS; the phase flag then switches to REP_TICKS
  // so the counter always reloads from zero instead of running past a limit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rep_phase_d = rep_phase_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    repeat_d    = 1'b0;
    hold_limit  = rep_phase_q ? REP_LAST : HOLD_LAST;
    case (state_q)
      LOW: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == DB_LAST) begin
            state_d     = HIGH;
            press_d     = 1'b1;
            cnt_d       = '0;
            rep_phase_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == hold_limit) begin
            repeat_d    = 1'b1;
            cnt_d       = '0;
            rep_phase_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d     = HIGH;
          cnt_d       = '0;
          rep_phase_d = 1'b0;
        end else if (tick) begin
          if (cnt_q == DB_LAST) begin
            state_d   = LOW;
            release_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = (state_q == HIGH) || (state_q == WAIT_LO);

endmodule

// File: rtl/key_debounce.sv
// Multi-channel key debouncer: per-bit synchronizers, a shared sample-tick
// prescaler and one debounce_chan per input.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned N          = N_DEF,
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned DB_TICKS   = DB_TICKS_DEF,
  parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF,
  parameter int unsigned REP_TICKS  = REP_TICKS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] repeat_pulse
);

  localparam int unsigned PW = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [N-1:0]  s_meta, s_sync;
  logic [PW-1:0] pre_q;
  logic          tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_meta <= '0;
      s_sync <= '0;
    end else begin
      s_meta <= raw_in;
      s_sync <= s_meta;
    end
  end

  assign tick = (pre_q == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_chan #(
      .DB_TICKS   (DB_TICKS),
      .HOLD_TICKS (HOLD_TICKS),
      .REP_TICKS  (REP_TICKS)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .s             (s_sync[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with small tick/debounce/repeat constants.
module tb_key_debounce;

  localparam int unsigned N = 11;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] raw_in;
  logic [N-1:0] level, press, release_pulse, repeat_pulse;

  int checks = 0;
  int errors = 0;

  int   found, reps, last;
  logic lvl, sticky, flag;

  key_debounce #(
    .N          (11),
    .TICK_DIV   (4),
    .DB_TICKS   (3),
    .HOLD_TICKS (8),
    .REP_TICKS  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .raw_in        (raw_in),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    raw_in = '0;
    for (int i = 0; i < 3; i++) cyc();
    check("rst_level",   32'(level), 32'h0);
    check("rst_press",   32'(press), 32'h0);
    check("rst_release", 32'(release_pulse), 32'h0);
    check("rst_repeat",  32'(repeat_pulse), 32'h0);
    rst = 1'b0;
    cyc();
    cyc();

    // Clean press on channel 0: 12..15 cycles depending on prescaler phase.
    raw_in[0] = 1'b1;
    found = -1;
    lvl   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (press[0]) begin
        found = i;
        lvl   = level[0];
        check("press0_only_ch0", 32'(press), 32'h001);
        break;
      end
    end
    check("press0_found",   32'(found >= 0), 32'd1);
    check("press0_lat_max", 32'(found <= 14), 32'd1);
    check("press0_lat_min", 32'(found >= 11), 32'd1);
    check("press0_level",   32'(lvl), 32'd1);
    cyc();
    check("press0_single",  32'(press[0]), 32'd0);
    check("press0_hold_lv", 32'(level[0]), 32'd1);

    // Bounce on channel 3: 5-cycle stable intervals never reach 3 ticks.
    sticky = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) raw_in[3] = ~raw_in[3];
      cyc();
      sticky = sticky | press[3] | release_pulse[3] | repeat_pulse[3] | level[3];
    end
    raw_in[3] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      sticky = sticky | press[3] | release_pulse[3] | repeat_pulse[3] | level[3];
    end
    check("bounce_no_event", 32'(sticky), 32'd0);
    check("bounce_level",    32'(level[3]), 32'd0);

    // Auto-repeat on channel 5 over 200 held cycles.
    raw_in[5] = 1'b1;
    found = -1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (press[5]) begin
        found = i;
        break;
      end
    end
    check("press5_found",   32'(found >= 0), 32'd1);
    check("press5_lat_max", 32'(found <= 14), 32'd1);
    check("press5_lat_min", 32'(found >= 11), 32'd1);
    reps = 0;
    last = 0;
    flag = 1'b0;
    for (int j = 1; j <= 200 - (found + 1); j++) begin
      cyc();
      if (press[5] || !level[5]) flag = 1'b1;
      if (repeat_pulse[5]) begin
        reps++;
        if (reps == 1) check("rep_first", 32'(j), 32'd32);
        else           check("rep_interval", 32'(j - last), 32'd16);
        last = j;
      end
    end
    check("rep_count",      32'(reps), 32'd10);
    check("rep_held_clean", 32'(flag), 32'd0);

    // Release on channel 5; repeat must stop once WAIT_LO is entered.
    raw_in[5] = 1'b0;
    found = -1;
    lvl   = 1'b1;
    flag  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i >= 2 && repeat_pulse[5]) flag = 1'b1;
      if (release_pulse[5]) begin
        found = i;
        lvl   = level[5];
        break;
      end
    end
    check("rel5_found",   32'(found >= 0), 32'd1);
    check("rel5_lat_max", 32'(found <= 14), 32'd1);
    check("rel5_lat_min", 32'(found >= 11), 32'd1);
    check("rel5_level",   32'(lvl), 32'd0);
    check("rel5_no_rep",  32'(flag), 32'd0);
    sticky = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      sticky = sticky | repeat_pulse[5] | release_pulse[5] | press[5];
    end
    check("after_rel5_quiet", 32'(sticky), 32'd0);

    // Reset while channel 0 is HIGH, then full re-debounce.
    check("pre_rst_level0", 32'(level[0]), 32'd1);
    rst = 1'b1;
    cyc();
    check("midrst_level",   32'(level), 32'h0);
    check("midrst_press",   32'(press), 32'h0);
    check("midrst_release", 32'(release_pulse), 32'h0);
    check("midrst_repeat",  32'(repeat_pulse), 32'h0);
    rst   = 1'b0;
    found = -1;
    flag  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (release_pulse[0]) flag = 1'b1;
      if (press[0]) begin
        found = i;
        break;
      end
    end
    check("rearm_press_cycle", 32'(found), 32'd11);
    check("rearm_no_release",  32'(flag), 32'd0);

    // All channels rise together.
    raw_in = '0;
    for (int i = 0; i < 30; i++) cyc();
    check("all_low", 32'(level), 32'h0);
    raw_in = '1;
    found = -1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (press != '0) begin
        found = i;
        check("all_press", 32'(press), 32'h7FF);
        break;
      end
    end
    check("all_press_found", 32'(found >= 0), 32'd1);
    check("all_press_lat",   32'(found >= 11 && found <= 14), 32'd1);
    cyc();
    check("all_press_single", 32'(press), 32'h0);
    check("all_level",        32'(level), 32'h7FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The module SHALL have parameter N, default 11, giving the number of input channels (key[4:0], key[5], bottom[4:0]).
REQ-002 The module SHALL have parameter TICK_DIV, default 1000, giving the clk cycles per sample tick.
REQ-003 The module SHALL have parameter DB_TICKS, default 20, giving the consecutive stable ticks needed to accept a level change.
REQ-004 The module SHALL have parameter HOLD_TICKS, default 500, giving the ticks of accepted-high before the first repeat pulse.
REQ-005 The module SHALL have parameter REP_TICKS, default 100, giving the ticks between subsequent repeat pulses.
REQ-006 Port clk SHALL be an input of width 1: the single clock (divided clock from clock_div); all logic is on its rising edge.
REQ-007 Port rst SHALL be an input of width 1: reset, synchronous and active-high.
REQ-008 Port raw_in SHALL be an input of width N: asynchronous, bouncing switch and button levels (1 = pressed).
REQ-009 Port level SHALL be an output of width N: the debounced level per channel.
REQ-010 Port press SHALL be an output of width N: a 1-cycle pulse on each accepted 0->1 change.
REQ-011 Port release SHALL be an output of width N: a 1-cycle pulse on each accepted 1->0 change.
REQ-012 Port repeat SHALL be an output of width N: a 1-cycle auto-repeat pulse while a channel is held.

Function
REQ-013 Each raw_in bit SHALL pass through a 2-flop synchronizer; all further logic SHALL use only the synchronized value s.
REQ-014 A shared prescaler SHALL count 0..TICK_DIV-1 and wrap to 0, asserting tick for exactly one cycle when it wraps.
REQ-015 Each channel SHALL run an FSM with states LOW, WAIT_HI, HIGH, WAIT_LO and one tick counter cnt.
REQ-016 In LOW, when s=1 the FSM SHALL go to WAIT_HI and clear cnt.
REQ-017 In WAIT_HI, when s=0 on any cycle (tick or not) the FSM SHALL return to LOW; on a tick with s=1 it SHALL increment cnt.
REQ-018 In WAIT_HI, on a tick with s=1 and cnt=DB_TICKS-1, the FSM SHALL go to HIGH, set level=1, pulse press the same cycle, and clear cnt.
REQ-019 WAIT_LO SHALL mirror WAIT_HI with s=0 as the target, a return to HIGH on s=1, and entry to LOW setting level=0 and pulsing release.
REQ-020 In HIGH, cnt SHALL count ticks; at cnt=HOLD_TICKS-1 the FSM SHALL pulse repeat, after which each REP_TICKS ticks SHALL pulse repeat again.
REQ-021 The repeat counter SHALL reload without overflow and SHALL never exceed max(HOLD_TICKS, REP_TICKS).
REQ-022 In HIGH, s=0 SHALL go to WAIT_LO and clear cnt, which stops repeat immediately.
REQ-023 level SHALL be 1 only in HIGH and WAIT_LO.
REQ-024 press, release and repeat SHALL be registered; press and repeat SHALL never be asserted in the same cycle on a channel.
REQ-025 Latency from a clean raw edge to press SHALL be 2 sync cycles plus the time to the DB_TICKS-th tick, i.e. at most 2+DB_TICKS*TICK_DIV+1 cycles.
REQ-026 Channels SHALL be fully independent: simultaneous changes on any subset SHALL produce simultaneous, independent pulses.
REQ-027 All counters SHALL be sized with clog2 of their limit.

Reset
REQ-028 While rst=1, the module SHALL place every channel in LOW, clear cnt, the prescaler and both synchronizer flops, and drive level, press, release and repeat to 0.
REQ-029 A reset asserted mid-WAIT or mid-HIGH SHALL abort the channel without emitting a release pulse.
REQ-030 After rst deasserts, a channel held pressed SHALL re-qualify through WAIT_HI (full debounce) before press.

Structure
REQ-031 A package key_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-032 The per-channel FSM and counter SHALL be a sub-module debounce_chan, instantiated N times by generate, with the prescaler and tick shared in key_debounce.

Verification (bench uses TICK_DIV=4, DB_TICKS=3, HOLD_TICKS=8, REP_TICKS=4, N=11)
REQ-033 Clean press: raw_in[0] goes 0->1 and is held; the bench SHALL see press[0] as a single pulse within 2+12+1 cycles, with level[0]=1 from that same cycle.
REQ-034 Bounce rejection: raw_in[3] toggles every 5 cycles for 60 cycles; the bench SHALL see no press, release or repeat on channel 3, and level[3]=0.
REQ-035 Auto-repeat: raw_in[5] is held 1 for 200 cycles; the bench SHALL see repeat[5] first 32 cycles (8 ticks) after press and then every 16 cycles, and no repeat after release.
REQ-036 Release: with channel 5 held, raw_in[5] drops to 0; the bench SHALL see release[5] after 3 stable ticks and level[5]=0 in the same cycle.
REQ-037 Reset mid-operation: rst=1 for 1 cycle while channel 0 is HIGH; the bench SHALL see all outputs 0 the next cycle, no release pulse, and a fresh press after re-debounce.
REQ-038 Simultaneous events: raw_in[10:0] all go 0->1 in the same cycle; the bench SHALL see press=11'h7FF for exactly one cycle.
